// File: rtl/upsample_frame_ctrl_if.sv
// Pixel FIFO read port plus valid/ready output stream with raster position.
interface upsample_frame_ctrl_if;
    localparam int unsigned DW = 8;
    localparam int unsigned CW = 10;

    logic          fifo_empty;
    logic [DW-1:0] fifo_dout;
    logic          fifo_rd_en;
    logic          out_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_row;
    logic [CW-1:0] out_col;

    // Controller side: pops the FIFO and drives the output stream
    modport master (
        input  fifo_empty, fifo_dout, out_ready,
        output fifo_rd_en, out_valid, out_data, out_row, out_col
    );

    // Environment side: supplies FIFO data and consumes the output stream
    modport slave (
        output fifo_empty, fifo_dout, out_ready,
        input  fifo_rd_en, out_valid, out_data, out_row, out_col
    );
endinterface

// File: rtl/upsample_frame_ctrl.sv
// 2x nearest-neighbour upsample sequencer: even output rows stream live from the
// FIFO (each pixel twice), odd output rows replay the captured source row.
module upsample_frame_ctrl #(
    parameter int unsigned SRC_W = 400,
    parameter int unsigned SRC_H = 300
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    upsample_frame_ctrl_if.master bus,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 underflow
);
    localparam int unsigned DW = 8;
    localparam int unsigned CW = 10;
    localparam int unsigned AW = (SRC_W > 1) ? $clog2(SRC_W) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(2 * SRC_W - 1);
    localparam logic [CW-1:0] ROW_LAST = CW'(2 * SRC_H - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROW_A = 2'd1,
        ROW_B = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] row;
    logic [CW-1:0] col;
    logic          uflow;
    logic [DW-1:0] linebuf [SRC_W];
    logic [AW-1:0] lb_addr;
    logic          valid_c;
    logic          rd_en_c;
    logic [DW-1:0] data_c;
    logic          xfer;
    logic          col_last;

    // Each source pixel covers two output columns
    assign lb_addr  = AW'(col >> 1);
    assign xfer     = valid_c & bus.out_ready;
    assign col_last = (col == COL_LAST);

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: rows alternate live/replay until the last replay pixel is accepted
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ROW_A;
            ROW_A:   if (xfer && col_last) state_nxt = ROW_B;
            ROW_B:   if (xfer && col_last) state_nxt = (row == ROW_LAST) ? DONE : ROW_A;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Stream outputs; the FIFO head is popped only once its second copy is accepted
    always_comb begin
        valid_c = 1'b0;
        data_c  = bus.fifo_dout;
        rd_en_c = 1'b0;
        case (state)
            ROW_A: begin
                valid_c = ~bus.fifo_empty;
                data_c  = bus.fifo_dout;
                rd_en_c = ~reset & ~bus.fifo_empty & bus.out_ready & col[0];
            end
            ROW_B: begin
                valid_c = 1'b1;
                data_c  = linebuf[lb_addr];
            end
            default: begin
                valid_c = 1'b0;
            end
        endcase
    end

    // Raster counters and sticky underflow flag
    always_ff @(posedge clock) begin
        if (reset) begin
            row   <= '0;
            col   <= '0;
            uflow <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                row   <= '0;
                col   <= '0;
                uflow <= 1'b0;
            end else if (xfer) begin
                if (col_last) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + CW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end
            if (state == ROW_A && bus.fifo_empty && bus.out_ready) begin
                uflow <= 1'b1;
            end
        end
    end

    // Capture each live source pixel on its first accepted copy for the replay row
    always_ff @(posedge clock) begin
        if (state == ROW_A && xfer && !col[0]) begin
            linebuf[lb_addr] <= bus.fifo_dout;
        end
    end

    assign bus.fifo_rd_en = rd_en_c;
    assign bus.out_valid  = valid_c;
    assign bus.out_data   = data_c;
    assign bus.out_row    = row;
    assign bus.out_col    = col;
    assign busy           = (state != IDLE);
    assign frame_done     = (state == DONE);
    assign underflow      = uflow;
endmodule

// File: tb/tb_upsample_frame_ctrl.sv
// Self-checking bench for upsample_frame_ctrl on a 4x2 source frame: a scenario
// table drives whole frames against a FIFO model and an expected-pixel scoreboard.
module tb_upsample_frame_ctrl;
    localparam int W     = 4;
    localparam int H     = 2;
    localparam int TOTAL = 4 * W * H;

    typedef struct packed {
        logic [7:0] base;
        int         mode;          // 0: ready always 1, 1: ready toggles 1,0,1,0
        int         empty_at;      // transfer count at which the FIFO reads empty (-1 none)
        int         empty_len;
        int         start_at;      // transfer count at which start is pulsed mid-frame
        int         reset_at;      // transfer count at which reset is pulsed
        bit         start_on_done;
        int         exp_xfers;
        int         exp_pops;
        int         exp_dones;
        bit         exp_uflow;
        int         exp_span;      // cycles from first to last transfer (0 = unchecked)
    } vec_t;

    typedef struct packed {
        logic [7:0] data;
        logic [9:0] row;
        logic [9:0] col;
    } pix_t;

    logic clock;
    logic reset;
    logic start;
    logic busy;
    logic frame_done;
    logic underflow;
    logic force_empty;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] fq[$];
    pix_t       exp_q[$];
    vec_t       vecs[8];

    upsample_frame_ctrl_if bus();

    upsample_frame_ctrl #(.SRC_W(W), .SRC_H(H)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .bus        (bus),
        .busy       (busy),
        .frame_done (frame_done),
        .underflow  (underflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish before 200000");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic drive_fifo();
        bus.fifo_empty = force_empty || (fq.size() == 0);
        bus.fifo_dout  = (fq.size() > 0) ? fq[0] : 8'h00;
    endtask

    // Runs one table entry; entered and left 1 time unit after a rising edge
    task automatic run_frame(input int idx, input vec_t v);
        int   xfers = 0;
        int   pops = 0;
        int   dones = 0;
        int   cyc = 0;
        int   first = -1;
        int   last = -1;
        int   empty_left = 0;
        bit   empty_started = 0;
        bit   start_done = 0;
        bit   stop = 0;
        bit   aborted = 0;
        bit   xfer;
        bit   rd;
        bit   exp_valid;
        bit   exp_rd;
        pix_t p;
        logic [7:0] dummy;

        for (int i = 0; i < W * H; i++) fq.push_back(8'(v.base + i));
        for (int r = 0; r < 2 * H; r++) begin
            for (int c = 0; c < 2 * W; c++) begin
                p.data = 8'(v.base + (r / 2) * W + c / 2);
                p.row  = 10'(r);
                p.col  = 10'(c);
                exp_q.push_back(p);
            end
        end

        force_empty   = 1'b0;
        bus.out_ready = 1'b1;
        start         = 1'b1;
        drive_fifo();
        @(negedge clock);
        chk($sformatf("v%0d_idle_valid", idx), 32'(bus.out_valid), 32'd0);
        chk($sformatf("v%0d_idle_busy", idx), 32'(busy), 32'd0);
        @(posedge clock);
        #1;

        while (!stop && cyc < 300) begin
            bus.out_ready = (v.mode == 1) ? (cyc % 2 == 0) : 1'b1;
            if (v.empty_at >= 0 && !empty_started && xfers == v.empty_at) begin
                empty_started = 1;
                empty_left    = v.empty_len;
            end
            force_empty = (empty_left > 0);
            if (empty_left > 0) empty_left--;
            start = 1'b0;
            if (xfers == v.start_at && !start_done) begin
                start      = 1'b1;
                start_done = 1;
            end
            if (v.start_on_done && xfers == TOTAL && dones == 0) start = 1'b1;
            reset = (v.reset_at >= 0 && xfers == v.reset_at);
            drive_fifo();
            @(negedge clock);

            if (reset) begin
                chk($sformatf("v%0d_rst_no_pop", idx), 32'(bus.fifo_rd_en), 32'd0);
                @(posedge clock);
                #1;
                reset = 1'b0;
                start = 1'b0;
                @(negedge clock);
                chk($sformatf("v%0d_rst_valid", idx), 32'(bus.out_valid), 32'd0);
                chk($sformatf("v%0d_rst_busy", idx), 32'(busy), 32'd0);
                chk($sformatf("v%0d_rst_row", idx), 32'(bus.out_row), 32'd0);
                chk($sformatf("v%0d_rst_col", idx), 32'(bus.out_col), 32'd0);
                chk($sformatf("v%0d_rst_uflow", idx), 32'(underflow), 32'd0);
                chk($sformatf("v%0d_rst_rd", idx), 32'(bus.fifo_rd_en), 32'd0);
                @(posedge clock);
                #1;
                aborted = 1;
                stop    = 1;
            end else begin
                if (cyc == 0) chk($sformatf("v%0d_uflow_clr", idx), 32'(underflow), 32'd0);
                chk($sformatf("v%0d_busy", idx), 32'(busy), 32'd1);
                if (exp_q.size() == 0) exp_valid = 0;
                else if (exp_q[0].row[0]) exp_valid = 1;
                else exp_valid = !force_empty && (fq.size() > 0);
                chk($sformatf("v%0d_valid_c%0d", idx, cyc), 32'(bus.out_valid), 32'(exp_valid));
                xfer = bus.out_valid && bus.out_ready;
                if (bus.out_valid && exp_q.size() > 0) begin
                    chk($sformatf("v%0d_pixel_c%0d", idx, cyc),
                        32'({bus.out_data, bus.out_row, bus.out_col}), 32'(exp_q[0]));
                end
                exp_rd = xfer && exp_q.size() > 0 && !exp_q[0].row[0] && exp_q[0].col[0];
                chk($sformatf("v%0d_rd_c%0d", idx, cyc), 32'(bus.fifo_rd_en), 32'(exp_rd));
                if (xfer) begin
                    if (exp_q.size() > 0) p = exp_q.pop_front();
                    xfers++;
                    if (first < 0) first = cyc;
                    last = cyc;
                end
                rd = bus.fifo_rd_en;
                if (rd) pops++;
                if (frame_done) begin
                    dones++;
                    chk($sformatf("v%0d_uflow_end", idx), 32'(underflow), 32'(v.exp_uflow));
                    stop = 1;
                end
                @(posedge clock);
                if (rd && fq.size() > 0) dummy = fq.pop_front();
                #1;
                cyc++;
            end
        end

        if (!stop) begin
            n_cmp++;
            n_fail++;
            $display("FAIL v%0d_timeout: got no frame end, required end within 300 cycles", idx);
        end

        if (!aborted && stop) begin
            start         = 1'b0;
            bus.out_ready = 1'b1;
            drive_fifo();
            @(negedge clock);
            chk($sformatf("v%0d_post_done", idx), 32'(frame_done), 32'd0);
            chk($sformatf("v%0d_post_busy", idx), 32'(busy), 32'd0);
            chk($sformatf("v%0d_post_valid", idx), 32'(bus.out_valid), 32'd0);
            @(posedge clock);
            #1;
        end

        chk($sformatf("v%0d_xfers", idx), 32'(xfers), 32'(v.exp_xfers));
        chk($sformatf("v%0d_pops", idx), 32'(pops), 32'(v.exp_pops));
        chk($sformatf("v%0d_dones", idx), 32'(dones), 32'(v.exp_dones));
        if (v.exp_span > 0) chk($sformatf("v%0d_span", idx), 32'(last - first + 1), 32'(v.exp_span));
        if (aborted) begin
            exp_q.delete();
            fq.delete();
        end else begin
            chk($sformatf("v%0d_sb_empty", idx), 32'(exp_q.size()), 32'd0);
            chk($sformatf("v%0d_fifo_drained", idx), 32'(fq.size()), 32'd0);
        end
        force_empty = 1'b0;
        drive_fifo();
    endtask

    initial begin
        //            base   mode eat elen sat  rat  sod  xf  pop dn uf span
        vecs[0] = '{8'd0,   0, -1, 0, -1, -1, 1'b1, 32, 8, 1, 1'b0, 32};
        vecs[1] = '{8'h20,  0,  3, 5, -1, -1, 1'b0, 32, 8, 1, 1'b1, 0};
        vecs[2] = '{8'h40,  1, -1, 0, -1, -1, 1'b0, 32, 8, 1, 1'b0, 0};
        vecs[3] = '{8'd0,   0, -1, 0, 10, -1, 1'b0, 32, 8, 1, 1'b0, 32};
        vecs[4] = '{8'd0,   0,  3, 5, -1, 29, 1'b0, 29, 8, 0, 1'b0, 0};
        vecs[5] = '{8'd10,  0, -1, 0, -1, -1, 1'b0, 32, 8, 1, 1'b0, 32};
        vecs[6] = '{8'h80,  0, -1, 0, -1,  1, 1'b0,  1, 0, 0, 1'b0, 0};
        vecs[7] = '{8'h90,  0, -1, 0, -1, -1, 1'b0, 32, 8, 1, 1'b0, 32};

        reset         = 1'b1;
        start         = 1'b0;
        force_empty   = 1'b0;
        bus.out_ready = 1'b1;
        drive_fifo();
        repeat (3) @(posedge clock);
        #1;
        start = 1'b1;
        @(negedge clock);
        chk("rst_hold_rd", 32'(bus.fifo_rd_en), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        start = 1'b0;
        @(negedge clock);
        chk("init_valid", 32'(bus.out_valid), 32'd0);
        chk("init_busy", 32'(busy), 32'd0);
        chk("init_done", 32'(frame_done), 32'd0);
        chk("init_uflow", 32'(underflow), 32'd0);
        chk("init_row", 32'(bus.out_row), 32'd0);
        chk("init_col", 32'(bus.out_col), 32'd0);
        chk("init_rd", 32'(bus.fifo_rd_en), 32'd0);
        @(posedge clock);
        #1;

        for (int i = 0; i < 8; i++) run_frame(i, vecs[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/upsample_frame_ctrl.md
Name: upsample_frame_ctrl

Overview:
Sequences a 2x nearest-neighbour upsample of one source frame from an 8-bit first-word-fall-through (FWFT) pixel FIFO into a valid/ready output stream.
- Horizontal doubling: each source pixel is emitted twice per output row.
- Vertical doubling: each source row is replayed once from an internal line buffer.
- Provides output raster counters, a frame-done pulse and a sticky FIFO-underflow flag.
- Sits between the camera/decimation FIFO and the DVI pixel path; owns all FIFO pops.

Parameters:
SRC_W, 400, source pixels per row; 2*SRC_W must be ≤ 1024.
SRC_H, 300, source rows per frame; 2*SRC_H must be ≤ 1024.

Ports:
clock  in  1  system clock; all logic on rising edge.
reset  in  1  synchronous, active-high reset.
start  in  1  one-cycle pulse that arms one frame; ignored while busy.
fifo_empty  in  1  FIFO has no data.
fifo_dout  in  8  FIFO head word; valid whenever fifo_empty=0.
fifo_rd_en  out  1  pop FIFO head this cycle.
out_ready  in  1  downstream accepts out_data this cycle.
out_valid  out  1  out_data is valid.
out_data  out  8  output pixel.
out_row  out  10  output row of the current out_data, 0..2*SRC_H-1.
out_col  out  10  output column of the current out_data, 0..2*SRC_W-1.
busy  out  1  frame in progress.
frame_done  out  1  one-cycle pulse after the last pixel of the frame is accepted.
underflow  out  1  sticky; FIFO was empty while downstream was ready in ROW_A.

Behaviour:
- Transfer: a transfer occurs on a cycle where out_valid=1 and out_ready=1.
- Reset values: state=IDLE; out_row=0, out_col=0; out_valid=0, fifo_rd_en=0, busy=0, frame_done=0, underflow=0. Line buffer contents are don't-care.
- States:
  - IDLE: out_valid=0. On start: go to ROW_A; row=col=0; underflow cleared.
  - ROW_A (live row, even output rows):
    - out_valid = !fifo_empty; out_data = fifo_dout.
    - On a transfer with col even: write linebuf[col>>1] = fifo_dout.
    - fifo_rd_en = out_valid & out_ready & col[0]; combinational. The FIFO head is popped only after its second copy is accepted.
  - ROW_B (replay row, odd output rows):
    - out_valid=1; out_data = linebuf[col>>1].
    - Line buffer: asynchronous read (distributed RAM), SRC_W x 8.
    - fifo_rd_en=0.
  - DONE: single cycle; frame_done=1; out_valid=0. Then go to IDLE.
- Counters:
  - col increments on each transfer.
  - At col=2*SRC_W-1 with a transfer: col wraps to 0 and row increments. State goes ROW_A→ROW_B or ROW_B→ROW_A.
  - At row=2*SRC_H-1, col=2*SRC_W-1, transfer in ROW_B: go to DONE. out_row/out_col return to 0.
- busy=1 in ROW_A, ROW_B and DONE.
- Throughput: one output pixel per cycle with no bubbles when out_ready=1 and the FIFO is non-empty. This includes the ROW_A↔ROW_B boundary and the first pixel of ROW_B, which is readable the cycle after the last ROW_A write.
- Backpressure: out_data, out_row and out_col hold stable while out_valid=1 and out_ready=0. In ROW_A, stability requires the FIFO head to hold, which it does because no pop occurs.
- Underflow: set when state=ROW_A, fifo_empty=1 and out_ready=1. Held until the next accepted start or reset. No other effect; the controller waits for data.
- start during busy: ignored; no counter or flag change.
- start on the same cycle as frame_done: ignored; a new start is required in IDLE.
- Reset mid-frame (any state): all outputs return to reset values the next cycle. No pop occurs on the reset cycle; fifo_rd_en is forced 0 while reset=1. FIFO contents are not flushed by this block.
- Total per frame: 4*SRC_W*SRC_H transfers and SRC_W*SRC_H pops.

Test Plan:
1. SRC_W=4, SRC_H=2; FIFO preloaded 0..7; out_ready=1; start.
   -> Rows 0/1 both emit 0,0,1,1,2,2,3,3; rows 2/3 both emit 4,4,5,5,6,6,7,7.
   -> 32 transfers in 32 consecutive cycles; fifo_rd_en pulses on cols 1,3,5,7 of rows 0 and 2 (8 pops).
   -> frame_done high exactly 1 cycle, then busy=0.
2. Same setup with out_ready toggling 1,0,1,0.
   -> Identical data/row/col sequence; outputs stable during stalls; exactly 8 pops, each coincident with a transfer.
3. Same setup; FIFO empty for 5 cycles at row 0, col 3, with out_ready=1.
   -> out_valid=0 for those cycles; underflow=1 and stays 1 to frame end; sequence resumes at col 3 with value 1.
   -> The next start clears underflow.
4. Pulse start at row 1, col 2 mid-frame.
   -> No effect; start in IDLE begins at row=0, col=0.
5. Assert reset at row 3, col 5 (ROW_B).
   -> Next cycle out_valid=0, busy=0, row=col=0, underflow=0, no pop.
   -> A fresh start with FIFO reloaded 10..17 yields first outputs 10,10,11,11.
6. Default parameters; counting FIFO; out_ready=1.
   -> 480000 transfers; max out_row=599, max out_col=799; 120000 pops; one frame_done.
